// File: rtl/seq_detect_param_if.sv
// Configuration, serial-input and detection-output bundle for seq_detect_param.
// The master modport drives config and data. The slave modport is the detector side.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               cfg_reg_out;
  logic               in_valid;
  logic               in_bit;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               primed;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_reg_out, in_valid, in_bit,
    input  match, match_count, primed
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_reg_out, in_valid, in_bit,
    output match, match_count, primed
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap control, Mealy or registered
// output and a saturating match counter. Reset state behaves as the legacy overlapping 1101 detector.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  seq_detect_param_if.slave  bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0]      LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0]      RST_LEN = (MAX_LEN < 4) ? LEN_MAX : LW'(4);
  localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0000_1101);

  logic [MAX_LEN-1:0] pattern, hist, cand, mask;
  logic [LW-1:0]      len, depth, depth_inc, len_m1, len_ld;
  logic               overlap, reg_out, match_r, primed, hit;
  logic [CNT_W-1:0]   count;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
  end

  assign cand      = {hist[MAX_LEN-2:0], bus.in_bit};
  assign len_m1    = len - 1'b1;
  assign primed    = (depth >= len_m1);
  // depth gates the compare, so stale history bits never produce a hit
  assign hit       = bus.in_valid && !bus.cfg_load && primed && (((cand ^ pattern) & mask) == '0);
  assign depth_inc = (depth == len) ? depth : depth + 1'b1;
  assign len_ld    = (bus.cfg_len == '0)     ? LW'(1)  :
                     (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= RST_PAT;
      len     <= RST_LEN;
      overlap <= 1'b1;
      reg_out <= 1'b0;
      hist    <= '0;
      depth   <= '0;
      match_r <= 1'b0;
      count   <= '0;
    end else if (bus.cfg_load) begin
      pattern <= bus.cfg_pattern;
      len     <= len_ld;
      overlap <= bus.cfg_overlap;
      reg_out <= bus.cfg_reg_out;
      depth   <= '0;
      match_r <= 1'b0;
      count   <= '0;
    end else begin
      match_r <= hit;
      if (bus.in_valid) begin
        hist  <= cand;
        depth <= (hit && !overlap) ? '0 : depth_inc;
      end
      if (hit && (count != '1)) count <= count + 1'b1;
    end
  end

  assign bus.match       = reg_out ? match_r : hit;
  assign bus.match_count = count;
  assign bus.primed      = primed;
endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: a queue-of-bits reference model predicts each cycle's outputs for two
// detector instances (16-bit and 2-bit counters), and a negedge monitor compares them.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detect_param_if #(.MAX_LEN(8), .CNT_W(16)) if0 ();
  seq_detect_param_if #(.MAX_LEN(8), .CNT_W(2))  if1 ();

  assign if1.cfg_load    = if0.cfg_load;
  assign if1.cfg_pattern = if0.cfg_pattern;
  assign if1.cfg_len     = if0.cfg_len;
  assign if1.cfg_overlap = if0.cfg_overlap;
  assign if1.cfg_reg_out = if0.cfg_reg_out;
  assign if1.in_valid    = if0.in_valid;
  assign if1.in_bit      = if0.in_bit;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(if0));
  seq_detect_param #(.MAX_LEN(8), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(if1));

  typedef struct {
    bit          match;
    int unsigned cnt;
    int unsigned cnt2;
    bit          primed;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: config plus the list of received bits still eligible for a match
  logic [7:0]  m_pat;
  int unsigned m_len;
  bit          m_ovl, m_ro, m_prev;
  bit          m_bits[$];
  int unsigned m_cnt, m_cnt2;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'h0D; m_len = 4; m_ovl = 1'b1; m_ro = 1'b0; m_prev = 1'b0;
    m_bits.delete(); m_cnt = 0; m_cnt2 = 0;
  endtask

  // drive one cycle, push its expected outputs, advance the model past the edge
  task automatic step(input bit ld, input logic [7:0] pat, input int len,
                      input bit ovl, input bit ro, input bit v, input bit b);
    exp_t e;
    bit   hit;
    int   sz;
    if0.cfg_load = ld; if0.cfg_pattern = pat; if0.cfg_len = 4'(len);
    if0.cfg_overlap = ovl; if0.cfg_reg_out = ro; if0.in_valid = v; if0.in_bit = b;
    sz = m_bits.size();
    hit = 1'b0;
    if (!ld && v && (sz + 1 >= int'(m_len))) begin
      hit = 1'b1;
      for (int k = 0; k < int'(m_len); k++)
        if (((k == 0) ? b : m_bits[sz - k]) != m_pat[k]) hit = 1'b0;
    end
    e.primed = (sz >= int'(m_len) - 1);
    e.match  = m_ro ? m_prev : hit;
    e.cnt    = m_cnt;
    e.cnt2   = m_cnt2;
    sb.push_back(e);
    if (ld) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : (len > 8) ? 8 : len;
      m_ovl = ovl; m_ro = ro; m_prev = 1'b0;
      m_bits.delete(); m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (v) begin
        m_bits.push_back(b);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        if (hit) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
          if (!m_ovl) m_bits.delete();
        end
      end
      m_prev = hit;
    end
    @(posedge clk); #1;
  endtask

  task automatic bit_in(input bit v, input bit b);
    step(1'b0, 8'h00, 0, 1'b0, 1'b0, v, b);
  endtask

  task automatic load(input logic [7:0] pat, input int len, input bit ovl, input bit ro);
    step(1'b1, pat, len, ovl, ro, 1'b0, 1'b0);
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(1'b1, bits[i]);
  endtask

  // asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic async_reset();
    if0.cfg_load = 1'b0; if0.in_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    check("async_rst_match", if0.match, 0);
    check("async_rst_count", if0.match_count, 0);
    check("async_rst_primed", if0.primed, 0);
    check("async_rst_count2", if1.match_count, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("match", if0.match, e.match);
      check("match_count", if0.match_count, e.cnt);
      check("primed", if0.primed, e.primed);
      check("match2", if1.match, e.match);
      check("match_count2", if1.match_count, e.cnt2);
    end
  end

  initial begin
    logic [7:0] rp;
    int         rl;
    reset = 1'b1;
    if0.cfg_load = 1'b0; if0.cfg_pattern = '0; if0.cfg_len = '0;
    if0.cfg_overlap = 1'b0; if0.cfg_reg_out = 1'b0; if0.in_valid = 1'b0; if0.in_bit = 1'b0;
    model_reset();
    #3;
    check("rst_match", if0.match, 0);
    check("rst_count", if0.match_count, 0);
    check("rst_primed", if0.primed, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    stream(16'b1101101, 7);                       // legacy overlapping 1101
    load(8'h0D, 4, 1'b0, 1'b0); stream(16'b1101101, 7);
    load(8'b101, 3, 1'b1, 1'b1);                  // registered, gapped input
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1, (i % 2 == 0)); bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b0);
    end
    load(8'h01, 1, 1'b1, 1'b0); stream(16'b11111, 5);  // counter saturation in the 2-bit instance
    load(8'h0D, 4, 1'b1, 1'b0); stream(16'b110, 3);
    step(1'b1, 8'h0D, 4, 1'b1, 1'b0, 1'b1, 1'b1);       // load wins over a valid bit
    stream(16'b1101, 4);
    load(8'hFF, 0, 1'b1, 1'b0); stream(16'hFF, 8);      // len 0 -> 1
    load(8'hFF, 11, 1'b1, 1'b0); stream(16'hFF, 8);     // len 11 -> 8
    load(8'b11, 2, 1'b1, 1'b1); stream(16'b111, 3);     // hit then load next cycle
    load(8'b11, 2, 1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b0, 1'b0);
    load(8'h0D, 4, 1'b1, 1'b0);
    stream(16'b110, 3); async_reset(); stream(16'b1101, 4);

    for (int blk = 0; blk < 30; blk++) begin
      rp = 8'($urandom);
      rl = ($urandom % 3 == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(1, 3));
      load(rp, rl, 1'($urandom), 1'($urandom));
      for (int c = 0; c < 50; c++) begin
        if ($urandom % 40 == 0)
          step(1'b1, 8'($urandom), int'($urandom_range(0, 11)), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
        else
          bit_in(($urandom % 4) != 0, 1'($urandom));
      end
    end

    @(negedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector. It supersedes the fixed 4-state "1101" Mealy detector with a runtime-programmable pattern of 1..MAX_LEN bits, an input-valid qualifier, selectable overlapping or non-overlapping detection, selectable combinational (Mealy) or registered output, and a saturating match counter. It sits on a serial bit stream behind any deserialiser or line receiver. Reset defaults reproduce the legacy overlapping 1101 Mealy detector exactly when in_valid is tied high.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits, ≥2.
- CNT_W, default 16: width of match_count.
- LW, derived as $clog2(MAX_LEN+1): width of cfg_len.
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- cfg_load  in  1  single-cycle strobe; captures cfg_* and re-arms the detector.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LW  pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cfg_reg_out  in  1  0 = Mealy (combinational) match, 1 = registered match.
- in_valid  in  1  qualifies in_bit.
- in_bit  in  1  serial data bit.
- match  out  1  one-cycle detection pulse.
- match_count  out  CNT_W  number of detections; saturates at all-ones.
- primed  out  1  history holds ≥ len-1 bits, so the next valid bit can complete a match.

## Operation
- Config registers: pattern, len, overlap, reg_out. Reset values are 8'b0000_1101 (zero-extended to MAX_LEN), 4, 1, 0.
- Effective length L is cfg_len clamped to the range 1..MAX_LEN: a value of 0 is taken as 1, and a value above MAX_LEN is taken as MAX_LEN. Clamping happens at load time.
- State:
  - hist[MAX_LEN-1:0] shift register of past bits.
  - depth counter in the range 0..L, counting valid history bits.
  - match_r.
  - match_count.
- Each cycle with in_valid=1 and cfg_load=0:
  - cand = {hist[MAX_LEN-2:0], in_bit}.
  - hit = (depth ≥ L-1) && (cand[L-1:0] == pattern[L-1:0]).
  - On hit with overlap=1: hist shifts and depth saturates at L.
  - On hit with overlap=0: hist shifts and depth is cleared to 0. Bits of the matched pattern are not reused.
  - On no hit: hist shifts, and depth increments, saturating at L.
- Cycles with in_valid=0: no state changes; hit=0.
- Output:
  - reg_out=0: match = hit, combinational from in_valid/in_bit. This is a Mealy output.
  - reg_out=1: match = match_r, where match_r <= hit.
- match_count increments on the edge that samples a hit, in both output modes, and holds once at 2^CNT_W-1.
- primed = (depth ≥ L-1).
- cfg_load on any cycle:
  - Captures all cfg_* fields.
  - Clears depth, match_r and match_count.
  - hist need not be cleared, because depth gates all compares.
- cfg_load has priority over in_valid in the same cycle. The in_bit of that cycle is discarded and hit is forced to 0.
- Asynchronous reset mid-stream aborts any partial match. All state returns to its reset values immediately.

## Timing
- Reset values of outputs: match=0, match_count=0, primed=0. With L=4, primed rises after the 3rd valid bit.
- Mealy mode:
  - Latency 0: match is high in the same cycle as the completing valid bit.
  - Downstream must sample match on the next edge.
- Registered mode: latency 1. match is high in the cycle after the completing bit, for exactly one cycle per hit.
- match_count reflects a hit one cycle after the completing bit in both modes.
- Back-to-back hits on consecutive valid bits are legal. Example: pattern 11, L=2, overlap=1, input 111 gives 2 pulses.
- A registered pulse whose hit was sampled before a cfg_load still appears if cfg_load is in the following cycle? No: cfg_load clears match_r on its edge. A hit in cycle N followed by cfg_load in cycle N+1 leaves match high during cycle N+1 only; no pulse appears after the load edge.
- A mode change takes effect from the first cycle after the cfg_load edge.
- L=1: every valid bit equal to pattern[0] hits. depth plays no gating role, and primed is constantly 1 after load.

## Test plan
- Reset defaults, in_valid=1, stream 1,1,0,1,1,0,1 → match high on bits 4 and 7 (same cycle as the bit); match_count=2; primed high after bit 3.
- Load overlap=0 (pattern 1101, L=4), same stream → single match on bit 4; match_count=1; primed drops after bit 4, then rises after bit 7.
- Registered mode, pattern 101, L=3, stream 1,0,1,0,1 with in_valid deasserted for 2 cycles between each bit → match one cycle after bits 3 and 5; no pulses during the idle cycles; count=2.
- CNT_W=2, pattern 1, L=1, 5 valid 1s → match on all 5; match_count goes 1,2,3,3,3.
- Mid-sequence cfg_load: send 1,1,0, then cfg_load (same pattern) coincident with a valid 1, then 1,1,0,1 → no match on the load cycle; match only on the final bit; count=1 after the load.
- cfg_len=0 and cfg_len=MAX_LEN+3 loads → behaviour equals L=1 and L=MAX_LEN respectively. Check with pattern all-ones on a stream of MAX_LEN ones: exactly one match on the last bit in the L=MAX_LEN case.
